// File: rtl/ysyx_22050550_imem_arb_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050550_imem_arb_pkg
// Shared definitions for the instruction-ROM arbiter:
//   - default bus widths (PC bus, instruction bus, ROM word index)
//   - FSM state encoding used by the arbiter/sequencer
//   - port identifiers for the two requesters (IFU = 0, LSU = 1)
// Optional feature macro used by the arbiter: YSYX_22050550_IMEM_ARB_RR_EN
// ---------------------------------------------------------------------------
package ysyx_22050550_imem_arb_pkg;

  // Default widths shared with the PC and instruction buses
  localparam int IMEM_PC_W   = 64;
  localparam int IMEM_INST_W = 32;
  localparam int IMEM_ROM_AW = 16;

  typedef enum logic [1:0] {
    IMEM_ARB_IDLE = 2'd0,
    IMEM_ARB_READ = 2'd1,
    IMEM_ARB_DATA = 2'd2,
    IMEM_ARB_RESP = 2'd3
  } imem_arb_state_e;

  localparam logic IMEM_PORT_IF = 1'b0;
  localparam logic IMEM_PORT_LS = 1'b1;

endpackage

// File: rtl/ysyx_22050550_arb2.sv
// ---------------------------------------------------------------------------
// ysyx_22050550_arb2
// Two-way grant logic for the instruction-ROM arbiter.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   req_i[1:0] : request vector, bit 0 = IFU, bit 1 = LSU
//   hs_i       : a request handshake happens this cycle
//   gnt_o[1:0] : one-hot grant (all zero when nobody requests)
// Macro YSYX_22050550_IMEM_ARB_RR_EN selects round-robin arbitration with a
// last_gnt register; without it LSU has fixed priority over IFU.
// ---------------------------------------------------------------------------
module ysyx_22050550_arb2
  import ysyx_22050550_imem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       hs_i,
  output logic [1:0] gnt_o
);

`ifdef YSYX_22050550_IMEM_ARB_RR_EN
  logic last_gnt_q;
  logic last_gnt_d;

  // On a conflict the port that did not win last time gets the grant
  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      if (last_gnt_q == IMEM_PORT_LS) begin
        gnt_o = 2'b01;
      end else begin
        gnt_o = 2'b10;
      end
    end else begin
      gnt_o = req_i;
    end
  end

  assign last_gnt_d = hs_i ? gnt_o[IMEM_PORT_LS] : last_gnt_q;

  // Reset to LSU so that IFU wins the very first conflict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= IMEM_PORT_LS;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`else
  // Fixed priority: LSU over IFU
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[IMEM_PORT_LS]) begin
      gnt_o = 2'b10;
    end else if (req_i[IMEM_PORT_IF]) begin
      gnt_o = 2'b01;
    end
  end

  // No state in this mode; clock, reset and handshake are intentionally unused
  logic unused_rr_inputs;
  assign unused_rr_inputs = ^{clk, rst_n, hs_i};
`endif

endmodule

// File: rtl/ysyx_22050550_imem_arb.sv
// ---------------------------------------------------------------------------
// ysyx_22050550_imem_arb
// Arbiter and sequencer in front of the single-port synchronous-read
// instruction ROM, shared by the IFU (port 0) and the LSU (port 1).
// Exactly one ROM read is in flight: IDLE -> READ -> DATA -> RESP -> IDLE.
// Ports:
//   clk, rst_n                               : clock, async active-low reset
//   if_req_valid/if_req_ready/if_req_addr    : IFU request channel
//   if_rsp_valid/if_rsp_ready/if_rsp_data    : IFU response channel
//   ls_req_valid/ls_req_ready/ls_req_addr    : LSU request channel
//   ls_rsp_valid/ls_rsp_ready/ls_rsp_data    : LSU response channel
//   rom_en, rom_addr                         : ROM read strobe and word index
//   rom_data                                 : ROM data, valid the cycle after rom_en
// Macro YSYX_22050550_IMEM_ARB_RR_EN: round-robin arbitration when defined,
// fixed LSU-over-IFU priority otherwise.
// ---------------------------------------------------------------------------
module ysyx_22050550_imem_arb
  import ysyx_22050550_imem_arb_pkg::*;
#(
  parameter int ADDR_W = IMEM_PC_W,
  parameter int DATA_W = IMEM_INST_W,
  parameter int ROM_AW = IMEM_ROM_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_req_addr,
  output logic              ls_rsp_valid,
  input  logic              ls_rsp_ready,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  imem_arb_state_e   state_q;
  logic              gnt_id_q;
  logic              rom_en_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic [1:0]        req_vec;
  logic [1:0]        gnt;
  logic              idle;
  logic              req_hs;
  logic              rsp_hs;
  logic [ROM_AW-1:0] sel_idx;

  // Gating with rst_n keeps both readies low while reset is held
  assign idle    = (state_q == IMEM_ARB_IDLE) && rst_n;
  assign req_vec = {ls_req_valid, if_req_valid};

  ysyx_22050550_arb2 u_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_vec),
    .hs_i  (req_hs),
    .gnt_o (gnt)
  );

  assign if_req_ready = idle && gnt[IMEM_PORT_IF];
  assign ls_req_ready = idle && gnt[IMEM_PORT_LS];
  assign req_hs       = (if_req_valid && if_req_ready) || (ls_req_valid && ls_req_ready);

  // Byte address to word index: drop the byte offset, truncate the top
  assign sel_idx = gnt[IMEM_PORT_LS] ? ls_req_addr[ROM_AW+1:2] : if_req_addr[ROM_AW+1:2];

  assign rsp_hs = (gnt_id_q == IMEM_PORT_LS) ? ls_rsp_ready : if_rsp_ready;

  // Sequencer: one ROM read per accepted request, response held until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IMEM_ARB_IDLE;
      gnt_id_q   <= IMEM_PORT_IF;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state_q)
        IMEM_ARB_IDLE: begin
          if (req_hs) begin
            gnt_id_q   <= gnt[IMEM_PORT_LS];
            rom_addr_q <= sel_idx;
            rom_en_q   <= 1'b1;
            state_q    <= IMEM_ARB_READ;
          end
        end
        IMEM_ARB_READ: begin
          rom_en_q <= 1'b0;
          state_q  <= IMEM_ARB_DATA;
        end
        IMEM_ARB_DATA: begin
          rsp_data_q <= rom_data;
          state_q    <= IMEM_ARB_RESP;
        end
        IMEM_ARB_RESP: begin
          if (rsp_hs) begin
            state_q <= IMEM_ARB_IDLE;
          end
        end
        default: begin
          state_q <= IMEM_ARB_IDLE;
        end
      endcase
    end
  end

  assign if_rsp_valid = (state_q == IMEM_ARB_RESP) && (gnt_id_q == IMEM_PORT_IF);
  assign ls_rsp_valid = (state_q == IMEM_ARB_RESP) && (gnt_id_q == IMEM_PORT_LS);
  assign if_rsp_data  = rsp_data_q;
  assign ls_rsp_data  = rsp_data_q;
  assign rom_en       = rom_en_q;
  assign rom_addr     = rom_addr_q;

  // Byte offset and address bits above the ROM are ignored by design
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_addr[ADDR_W-1:ROM_AW+2], if_req_addr[1:0],
                              ls_req_addr[ADDR_W-1:ROM_AW+2], ls_req_addr[1:0]};

endmodule

// File: tb/tb_ysyx_22050550_imem_arb.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050550_imem_arb
// Directed bench for the instruction-ROM arbiter. A transaction-level model
// (busy flag, cycles since acceptance, owning port) predicts every output on
// every falling edge; directed scenarios add literal expectations.
// Honours YSYX_22050550_IMEM_ARB_RR_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_ysyx_22050550_imem_arb;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;
  localparam int ROM_AW = 16;

  logic              clk          = 1'b0;
  logic              rst_n        = 1'b0;
  logic              if_req_valid = 1'b0;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr  = '0;
  logic              if_rsp_valid;
  logic              if_rsp_ready = 1'b1;
  logic [DATA_W-1:0] if_rsp_data;
  logic              ls_req_valid = 1'b0;
  logic              ls_req_ready;
  logic [ADDR_W-1:0] ls_req_addr  = '0;
  logic              ls_rsp_valid;
  logic              ls_rsp_ready = 1'b1;
  logic [DATA_W-1:0] ls_rsp_data;
  logic              rom_en;
  logic [ROM_AW-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data     = '0;

  always #5 clk = ~clk;

  ysyx_22050550_imem_arb #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ROM_AW (ROM_AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_ready (if_rsp_ready),
    .if_rsp_data  (if_rsp_data),
    .ls_req_valid (ls_req_valid),
    .ls_req_ready (ls_req_ready),
    .ls_req_addr  (ls_req_addr),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_ready (ls_rsp_ready),
    .ls_rsp_data  (ls_rsp_data),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data)
  );

  int vectorCount = 0;
  int missCount   = 0;
  int grantLog[$];
  int romEnCount  = 0;

  // ROM contents: word 1 is a real instruction, every other word is {idx, ~idx}
  function automatic logic [31:0] romWord(input logic [15:0] idx);
    if (idx == 16'd1) return 32'h0010_0093;
    return {idx, ~idx};
  endfunction

  // Synchronous-read ROM; outside the read slot the bus carries junk
  always @(posedge clk) begin
    rom_data <= rom_en ? romWord(rom_addr) : 32'hDEAD_BEEF;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifV, input logic [63:0] ifA,
                               input logic lsV, input logic [63:0] lsA,
                               input logic ifRr, input logic lsRr);
    if_req_valid = ifV;
    if_req_addr  = ifA;
    ls_req_valid = lsV;
    ls_req_addr  = lsA;
    if_rsp_ready = ifRr;
    ls_rsp_ready = lsRr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sampleNeg();
    @(negedge clk);
    #1;
  endtask

  // Transaction-level model state
  bit          mBusy    = 1'b0;
  int          mAge     = 0;
  int          mPort    = 0;
  int          mLastGnt = 1;
  logic [15:0] mIdx     = '0;
  logic [31:0] mHeld    = '0;
  int          mGrant;
  logic [63:0] mAddr;
  logic        eIfRdy, eLsRdy, eIfRv, eLsRv, eRomEn;

  // Compare process: predict outputs from the model, compare, then advance
  initial begin
    forever begin
      @(negedge clk);
      mGrant = -1;
      if (!rst_n) begin
        mBusy = 1'b0; mAge = 0; mLastGnt = 1; mIdx = '0; mHeld = '0;
        eIfRdy = 1'b0; eLsRdy = 1'b0; eIfRv = 1'b0; eLsRv = 1'b0; eRomEn = 1'b0;
      end else begin
        if (!mBusy) begin
          if (if_req_valid && ls_req_valid) begin
`ifdef YSYX_22050550_IMEM_ARB_RR_EN
            mGrant = (mLastGnt == 1) ? 0 : 1;
`else
            mGrant = 1;
`endif
          end else if (if_req_valid) begin
            mGrant = 0;
          end else if (ls_req_valid) begin
            mGrant = 1;
          end
        end
        eIfRdy = (mGrant == 0);
        eLsRdy = (mGrant == 1);
        eRomEn = mBusy && (mAge == 1);
        eIfRv  = mBusy && (mAge == 3) && (mPort == 0);
        eLsRv  = mBusy && (mAge == 3) && (mPort == 1);
      end
      checkOutput("cmp if_req_ready", if_req_ready, eIfRdy);
      checkOutput("cmp ls_req_ready", ls_req_ready, eLsRdy);
      checkOutput("cmp if_rsp_valid", if_rsp_valid, eIfRv);
      checkOutput("cmp ls_rsp_valid", ls_rsp_valid, eLsRv);
      checkOutput("cmp rom_en", rom_en, eRomEn);
      checkOutput("cmp rom_addr", rom_addr, mIdx);
      checkOutput("cmp if_rsp_data", if_rsp_data, mHeld);
      checkOutput("cmp ls_rsp_data", ls_rsp_data, mHeld);
      if (rst_n && if_req_valid && if_req_ready) grantLog.push_back(0);
      if (rst_n && ls_req_valid && ls_req_ready) grantLog.push_back(1);
      if (rom_en) romEnCount++;
      if (rst_n) begin
        if (!mBusy) begin
          if (mGrant >= 0) begin
            mAddr    = (mGrant == 1) ? ls_req_addr : if_req_addr;
            mIdx     = 16'((mAddr / 4) % 65536);
            mBusy    = 1'b1;
            mAge     = 1;
            mPort    = mGrant;
            mLastGnt = mGrant;
          end
        end else if (mAge == 1) begin
          mAge = 2;
        end else if (mAge == 2) begin
          mAge  = 3;
          mHeld = romWord(mIdx);
        end else if ((mPort == 0 && if_rsp_ready) || (mPort == 1 && ls_rsp_ready)) begin
          mBusy = 1'b0;
        end
      end
    end
  end

  // One complete read with literal checks on the ROM strobe and the response
  task automatic singleRead(input int port, input logic [63:0] addr,
                            input logic [15:0] expIdx, input logic [31:0] expData,
                            input string tag);
    if (port == 0) applyStimulus(1'b1, addr, 1'b0, '0, 1'b1, 1'b1);
    else           applyStimulus(1'b0, '0, 1'b1, addr, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    sampleNeg();
    checkOutput({tag, " rom_en"}, rom_en, 1'b1);
    checkOutput({tag, " rom_addr"}, rom_addr, expIdx);
    sampleNeg();
    sampleNeg();
    if (port == 0) begin
      checkOutput({tag, " if_rsp_valid"}, if_rsp_valid, 1'b1);
      checkOutput({tag, " if_rsp_data"}, if_rsp_data, expData);
    end else begin
      checkOutput({tag, " ls_rsp_valid"}, ls_rsp_valid, 1'b1);
      checkOutput({tag, " ls_rsp_data"}, ls_rsp_data, expData);
    end
    tick();
  endtask

  int expGrants[4];

  initial begin
`ifdef YSYX_22050550_IMEM_ARB_RR_EN
    expGrants = '{0, 1, 0, 1};
`else
    expGrants = '{1, 1, 1, 1};
`endif
    // Reset held with both requesters valid
    applyStimulus(1'b1, 64'h8000_0000, 1'b1, 64'h8000_0004, 1'b1, 1'b1);
    repeat (3) tick();
    sampleNeg();
    checkOutput("reset if_req_ready", if_req_ready, 1'b0);
    checkOutput("reset ls_req_ready", ls_req_ready, 1'b0);
    checkOutput("reset rom_en", rom_en, 1'b0);
    checkOutput("reset rom_addr", rom_addr, 16'h0);
    checkOutput("reset ls_rsp_valid", ls_rsp_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    sampleNeg();
`ifdef YSYX_22050550_IMEM_ARB_RR_EN
    checkOutput("first grant if_req_ready", if_req_ready, 1'b1);
    checkOutput("first grant ls_req_ready", ls_req_ready, 1'b0);
`else
    checkOutput("first grant if_req_ready", if_req_ready, 1'b0);
    checkOutput("first grant ls_req_ready", ls_req_ready, 1'b1);
`endif
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    repeat (3) tick();

    // Single IFU read of ROM word 1
    singleRead(0, 64'h8000_0004, 16'h0001, 32'h0010_0093, "single if");

    // LSU response backpressure with IFU waiting
    applyStimulus(1'b0, '0, 1'b1, 64'h8000_0010, 1'b1, 1'b0);
    romEnCount = 0;
    tick();
    applyStimulus(1'b1, 64'h8000_0000, 1'b0, '0, 1'b1, 1'b0);
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      sampleNeg();
      checkOutput($sformatf("backpressure ls_rsp_valid %0d", i), ls_rsp_valid, 1'b1);
      checkOutput($sformatf("backpressure ls_rsp_data %0d", i), ls_rsp_data, 32'h0004_FFFB);
      checkOutput($sformatf("backpressure if_req_ready %0d", i), if_req_ready, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    tick();
    checkOutput("backpressure rom_en pulses", romEnCount, 1);

    // Continuous conflict
    grantLog.delete();
    applyStimulus(1'b1, 64'h8000_0020, 1'b1, 64'h8000_0024, 1'b1, 1'b1);
    repeat (16) tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("conflict grant count", grantLog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grantLog.size()) begin
        checkOutput($sformatf("conflict grant %0d", i), grantLog[i], expGrants[i]);
      end
    end
    tick();

    // Reset arriving while the ROM read strobe is high
    applyStimulus(1'b1, 64'h8000_0008, 1'b0, '0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("pre-reset rom_en", rom_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset rom_en", rom_en, 1'b0);
    checkOutput("async reset rom_addr", rom_addr, 16'h0);
    checkOutput("async reset if_rsp_data", if_rsp_data, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    sampleNeg();
    checkOutput("post-reset stale if_rsp_valid", if_rsp_valid, 1'b0);
    tick();
    singleRead(1, 64'h8000_000C, 16'h0003, 32'h0003_FFFC, "post-reset ls");

    // Byte offset ignored and upper address bits truncated
    singleRead(0, 64'h8000_0007, 16'h0001, 32'h0010_0093, "low bits");
    singleRead(0, 64'h0000_0001_2345_6788, 16'h59E2, 32'h59E2_A61D, "truncate");

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ysyx_22050550_imem_arb.md
# ysyx_22050550_imem_arb

Two-port arbiter and sequencer for the single-port, synchronous-read instruction ROM. It serves the instruction fetch unit (IFU, port 0) and the load/store unit (LSU, port 1), which reads constants embedded in the text segment. Each port uses a valid/ready request channel and a valid/ready response channel. The block sits between IFU/LSU and the ROM, and exactly one ROM read is in flight at any time.

## Interface
- `ADDR_W`, default 64: byte address width, equal to the PC bus width.
- `DATA_W`, default 32: instruction/word width.
- `ROM_AW`, default 16: ROM word-index width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req_valid` in 1 / `if_req_ready` out 1 / `if_req_addr` in ADDR_W: IFU request channel.
- `if_rsp_valid` out 1 / `if_rsp_ready` in 1 / `if_rsp_data` out DATA_W: IFU response channel.
- `ls_req_valid` in 1 / `ls_req_ready` out 1 / `ls_req_addr` in ADDR_W: LSU request channel.
- `ls_rsp_valid` out 1 / `ls_rsp_ready` in 1 / `ls_rsp_data` out DATA_W: LSU response channel.
- `rom_en` out 1: ROM read strobe.
- `rom_addr` out ROM_AW: ROM word index.
- `rom_data` in DATA_W: ROM read data, valid the cycle after `rom_en`.

## Operation
- FSM states: IDLE → READ → DATA → RESP → IDLE.
- **IDLE**
  - Compute the grant from the two `*_req_valid` inputs.
  - `*_req_ready` = 1 only for the granted port, and only in IDLE; the other port's ready = 0.
  - Handshake = valid & ready. On a handshake, latch `gnt_id` and `rom_addr <= addr[ROM_AW+1:2]`, then go to READ.
  - `addr[1:0]` is ignored; the word index truncates the upper bits.
- **READ**: `rom_en` = 1 for exactly this cycle, then go to DATA.
- **DATA**: `rsp_data_q <= rom_data`, then go to RESP.
- **RESP**
  - `rsp_valid` = 1 on the port selected by `gnt_id`; both `*_rsp_data` carry `rsp_data_q`.
  - Valid stays high and data stays stable until that port's `rsp_ready` = 1, then go to IDLE.
- The other port's `rsp_valid` is never asserted while it is not granted.
- No new request is accepted before the previous response handshake completes. Back-to-back requests from one port therefore accept every 4 cycles at best.
- A requester dropping `req_valid` before the handshake is legal; no grant is recorded for it.
- Reset is asynchronous and may arrive mid-transaction:
  - The FSM returns to IDLE and the in-flight response is discarded.
  - `last_gnt` resets to LSU, so IFU wins the first conflict.

## Timing
- Reset values: `if_req_ready` = `ls_req_ready` = 0 while `rst_n` = 0, and combinational from IDLE afterwards. `if_rsp_valid` = `ls_rsp_valid` = 0. `if_rsp_data` = `ls_rsp_data` = 0. `rom_en` = 0. `rom_addr` = 0.
- Latency: with the request handshake in cycle N, `rom_en` is high in N+1, data is captured at the end of N+2, and `rsp_valid` rises in N+3.
- `*_req_ready` depends combinationally on `*_req_valid` and state. No output depends combinationally on `*_rsp_ready`.
- Simultaneous valid requests are resolved per Configuration. Arbitration is evaluated only in IDLE; a request arriving in any other state waits.

## Configuration
- Macro: `YSYX_22050550_IMEM_ARB_RR_EN`.
- Defined: round-robin arbitration. On conflict, grant the port not recorded in `last_gnt`; `last_gnt` updates on each request handshake.
- Undefined: fixed priority, LSU over IFU. `last_gnt` is not implemented.
- In both modes, a single requester is granted immediately in IDLE.

## Structure
- The shared define file holds:
  - the FSM state encodings `IMEM_ARB_IDLE` / `READ` / `DATA` / `RESP` (2 bits);
  - the port IDs `IMEM_PORT_IF` = 0 and `IMEM_PORT_LS` = 1;
  - default widths reused from the existing PC and instruction bus defines.
- One natural sub-module, `ysyx_22050550_arb2`: 2-way grant logic (request vector in, one-hot grant out, `last_gnt` state under the RR macro). The FSM and datapath registers stay in the top.

## Test plan
- **Reset**: hold `rst_n` = 0 with both request valids high → all readies, rsp_valids, `rom_en` and `rom_addr` = 0. Release reset → IFU is granted first.
- **Single IFU read**: IFU requests addr 0x8000_0004 with ROM word 1 = 0x0010_0093 → `rom_en` in the cycle after the handshake with `rom_addr` = 1, then `if_rsp_valid` with data 0x0010_0093 three cycles after the handshake.
- **Conflict**: both ports hold valid continuously.
  - With `_RR_EN`: grants alternate IF, LS, IF, LS.
  - Without it: LS is granted every time while LS stays valid.
- **Response backpressure**: `ls_rsp_ready` = 0 for 5 cycles → `ls_rsp_valid` and data held stable, `if_req_ready` stays 0, a single `rom_en` pulse total.
- **Reset mid-transaction**: assert `rst_n` low in READ → all outputs 0 asynchronously. After release, no stale `rsp_valid` appears and a new request completes normally.
- **Ignored low bits**: addr 0x8000_0007 → `rom_addr` = 1; addr with bits above `ROM_AW+1` set → index truncated.
